// File: rtl/apb_timer.sv
// APB slave timer: four memory-mapped registers and a prescaled down-counter.
// Raises a level interrupt on underflow and supports one-shot and periodic modes.
module apb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  IRQ
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_VALUE  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [DATA_WIDTH-1:0] VALUE_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic                  r_en;
    logic                  r_periodic;
    logic                  r_ie;
    logic [7:0]            r_prescale;
    logic [DATA_WIDTH-1:0] r_load;
    logic [DATA_WIDTH-1:0] r_value;
    logic                  r_pend;
    logic [7:0]            r_pcnt;

    logic [1:0] w_addr;
    logic       w_wr;
    logic       w_wrCtrl;
    logic       w_wrLoad;
    logic       w_wrStatus;
    logic       w_tick;
    logic       w_underflow;
    logic       w_enNext;
    logic       w_unusedAddr;

    assign w_addr       = PADDR[3:2];
    assign w_unusedAddr = ^{PADDR[ADDR_WIDTH-1:4], PADDR[1:0]};

    assign w_wr        = PSEL & PENABLE & PWRITE;
    assign w_wrCtrl    = w_wr & (w_addr == ADDR_CTRL);
    assign w_wrLoad    = w_wr & (w_addr == ADDR_LOAD);
    assign w_wrStatus  = w_wr & (w_addr == ADDR_STATUS);

    assign w_tick      = r_en & (r_pcnt == r_prescale);
    assign w_underflow = w_tick & (r_value == '0);

    // A CTRL write beats the one-shot auto-stop on the same edge.
    always_comb begin
        w_enNext = r_en;
        if (w_wrCtrl) begin
            w_enNext = PWDATA[0];
        end else if (w_underflow && !r_periodic) begin
            w_enNext = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_ie       <= 1'b0;
            r_prescale <= 8'd0;
            r_load     <= '0;
        end else begin
            r_en <= w_enNext;
            if (w_wrCtrl) begin
                r_periodic <= PWDATA[1];
                r_ie       <= PWDATA[2];
                r_prescale <= PWDATA[15:8];
            end
            if (w_wrLoad) begin
                r_load <= PWDATA;
            end
        end
    end

    // Prescaler restarts from zero on LOAD writes and whenever counting is off.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pcnt <= 8'd0;
        end else if (w_wrLoad || !r_en || !w_enNext || w_tick) begin
            r_pcnt <= 8'd0;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_value <= '0;
        end else if (w_wrLoad) begin
            r_value <= PWDATA;
        end else if (w_tick) begin
            if (r_value != '0) begin
                r_value <= r_value - VALUE_ONE;
            end else if (r_periodic) begin
                r_value <= r_load;
            end else begin
                r_value <= '0;
            end
        end
    end

    // Underflow set has priority over a same-edge write-1-to-clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pend <= 1'b0;
        end else if (w_underflow) begin
            r_pend <= 1'b1;
        end else if (w_wrStatus && PWDATA[0]) begin
            r_pend <= 1'b0;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (w_addr)
                ADDR_CTRL: begin
                    PRDATA[0]    = r_en;
                    PRDATA[1]    = r_periodic;
                    PRDATA[2]    = r_ie;
                    PRDATA[15:8] = r_prescale;
                end
                ADDR_LOAD:   PRDATA = r_load;
                ADDR_VALUE:  PRDATA = r_value;
                ADDR_STATUS: PRDATA[0] = r_pend;
                default:     PRDATA = '0;
            endcase
        end
    end

    assign IRQ = r_pend & r_ie;

endmodule

// File: doc/apb_timer.md
# apb_timer

APB slave timer peripheral that sits directly downstream of the AHB-to-APB bridge. It decodes the bridge's APB setup/enable accesses into four memory-mapped registers and runs a prescaled down-counter. The counter raises a level interrupt on underflow and supports one-shot and periodic modes. The APB interface has no PREADY or PSLVERR: every access completes in the two-cycle setup/enable sequence the bridge generates.

## Interface

Parameters:
- ADDR_WIDTH, 32, APB address width; only PADDR[3:2] is decoded.
- DATA_WIDTH, 32, APB data width and width of the LOAD and VALUE registers; minimum 16.

Ports:
- PCLK  in  1  single clock, shared with the bridge.
- PRESET  in  1  reset, asynchronous, active-high.
- PSEL  in  1  slave select from the bridge.
- PENABLE  in  1  access (enable) phase.
- PADDR  in  ADDR_WIDTH  register address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data.
- IRQ  out  1  interrupt, level, active-high.

## Operation

- Register map, selected by PADDR[3:2]; upper address bits are ignored:
  - 0x0 CTRL (R/W): bit0 EN, bit1 PERIODIC, bit2 IE, bits[15:8] PRESCALE. All other bits read 0.
  - 0x4 LOAD (R/W): reload value.
  - 0x8 VALUE (RO): current count. Writes are ignored.
  - 0xC STATUS: bit0 PEND. Write 1 to clear; writing 0 has no effect.
- Write commit: a write takes effect on the rising edge where PSEL & PENABLE & PWRITE are all 1. The setup phase has no side effects.
- A write to LOAD updates both LOAD and VALUE, and clears the prescale counter.
- Read: PRDATA is combinational from PADDR[3:2] whenever PSEL=1 and PWRITE=0, so it is valid in both setup and enable phases. Otherwise PRDATA = 0. Reads have no side effects.
- Prescaler: an 8-bit counter PCNT runs while EN=1.
  - tick = EN & (PCNT == PRESCALE).
  - On tick, PCNT returns to 0; otherwise PCNT increments.
  - PCNT is held at 0 while EN=0.
- Counter, on tick:
  - If VALUE != 0, VALUE decrements by 1.
  - If VALUE == 0 (underflow), PEND is set to 1. Then:
    - PERIODIC=1: VALUE reloads from LOAD.
    - PERIODIC=0: VALUE stays at 0 and EN clears to 0 (one-shot stop).
- IRQ = PEND & IE. Both terms are registered, so IRQ is glitch-free.
- Per-cycle priority:
  - Tick logic evaluates the pre-edge register state.
  - A same-cycle APB write to CTRL or LOAD overrides the tick's update of EN or VALUE.
  - An underflow set of PEND wins over a same-cycle W1C clear.
- LOAD = 0 with EN=1 and PERIODIC=1 underflows on every tick. This is legal.
- Writing CTRL with EN=0 stops counting immediately. VALUE is held and PEND is unchanged.

## Timing

- Reset (PRESET=1, asynchronous): CTRL, LOAD, VALUE, PEND and PCNT all clear to 0. IRQ and PRDATA are 0.
- Reset mid-operation aborts counting at once. The first access after release behaves as after power-up.
- Tick period = PRESCALE+1 cycles. Underflow period = (LOAD+1) × (PRESCALE+1) cycles.
- Enabling at edge E (PCNT=0) with PRESCALE=0 and LOAD=L: VALUE = L−1 after edge E+1, and PEND/IRQ rise after edge E+L+1.
- A W1C write at edge W drops IRQ after edge W, unless an underflow occurs at edge W.
- Read latency: 0 cycles. Data is stable through the bridge's enable phase.

## Test plan

- Reset values: assert PRESET mid-count with LOAD=5 and EN=1 -> all registers read 0 and IRQ=0 after release.
- One-shot: LOAD=3, CTRL=0x5 (EN, IE, PRESCALE=0) -> VALUE reads 2,1,0 on successive cycles; IRQ=1 four cycles after the enable edge; CTRL reads 0x4; VALUE stays 0.
- Periodic with prescale: LOAD=2, CTRL=0x0207 -> tick every 3 cycles; PEND set every 9 cycles; VALUE sequence 2,1,0,2…
- W1C vs. underflow collision: STATUS write of 1 on the same edge as an underflow -> PEND stays 1. A later write of 1 -> IRQ=0 on the next cycle.
- LOAD write during count: counting with VALUE=7, write LOAD=0x10 on a tick edge -> VALUE=0x10 and PCNT=0. A write to VALUE is ignored.
- Back-to-back accesses through the bridge: write CTRL, then read CTRL, then read VALUE -> PRDATA correct in each enable phase; PRDATA=0 when PSEL=0.
